// File: rtl/score_display_ctrl.sv
// Score readout sequencer: accepts binary scores, converts them to BCD by double-dabble
// (or passes raw hex), and drives committed digit codes plus a leading-zero/blink blank mask.
module score_display_ctrl #(
    parameter int unsigned SCORE_W   = 14,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               score_valid,
    input  logic [SCORE_W-1:0] score,
    input  logic               hex_mode,
    output logic               score_ready,
    input  logic               blink_en,
    output logic [15:0]        digits,
    output logic [3:0]         blank,
    output logic               busy
);

    localparam int unsigned SH_W  = SCORE_W + 16;
    localparam int unsigned BIT_W = $clog2(SCORE_W + 1);
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCORE_W-1:0] SAT_MAX = SCORE_W'(9999);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [SH_W-1:0]    sh;
    logic [BIT_W-1:0]   bit_cnt;
    logic               hex_wait;
    logic [3:0]         lz;
    logic [BLK_W-1:0]   blk_cnt;
    logic               blk_off;

    logic [SH_W-1:0]    sh_adj;
    logic [SH_W-1:0]    sh_shift;
    logic [SCORE_W-1:0] sat;
    logic [BLK_W-1:0]   blk_cnt_n;
    logic               blk_off_n;
    logic               commit;
    logic [15:0]        digits_n;
    logic [3:0]         lz_n;

    // Blank every upper digit that has only zeros above and including it; ones digit always shown.
    function automatic logic [3:0] lead_zero(input logic [11:0] d_hi);
        logic [3:0] m;
        m[3] = (d_hi[11:8] == 4'd0);
        m[2] = m[3] && (d_hi[7:4] == 4'd0);
        m[1] = m[2] && (d_hi[3:0] == 4'd0);
        m[0] = 1'b0;
        return m;
    endfunction

    assign sat = (score > SAT_MAX) ? SAT_MAX : score;

    // One double-dabble iteration: add-3 correction on each BCD nibble, then shift left.
    always_comb begin
        sh_adj = sh;
        for (int i = 0; i < 4; i++) begin
            if (sh[SCORE_W + 4*i +: 4] >= 4'd5) begin
                sh_adj[SCORE_W + 4*i +: 4] = sh[SCORE_W + 4*i +: 4] + 4'd3;
            end
        end
        sh_shift = sh_adj << 1;
    end

    // Blink phase advances only while enabled; disabling snaps back to ON with a cleared count.
    always_comb begin
        blk_cnt_n = blk_cnt;
        blk_off_n = blk_off;
        if (!blink_en) begin
            blk_cnt_n = '0;
            blk_off_n = 1'b0;
        end else if (blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
            blk_cnt_n = '0;
            blk_off_n = ~blk_off;
        end else begin
            blk_cnt_n = blk_cnt + 1'b1;
        end
    end

    always_comb begin
        commit   = (state == DONE) && !hex_wait;
        digits_n = commit ? sh[SH_W-1 -: 16] : digits;
        lz_n     = commit ? lead_zero(sh[SH_W-1 -: 12]) : lz;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            sh          <= '0;
            bit_cnt     <= '0;
            hex_wait    <= 1'b0;
            digits      <= 16'h0000;
            lz          <= 4'b1110;
            blank       <= 4'b1110;
            score_ready <= 1'b0;
            busy        <= 1'b0;
            blk_cnt     <= '0;
            blk_off     <= 1'b0;
        end else begin
            blk_cnt <= blk_cnt_n;
            blk_off <= blk_off_n;
            digits  <= digits_n;
            lz      <= lz_n;
            blank   <= lz_n | {4{blk_off_n}};
            case (state)
                IDLE: begin
                    score_ready <= 1'b1;
                    if (score_valid && score_ready) begin
                        score_ready <= 1'b0;
                        busy        <= 1'b1;
                        if (hex_mode) begin
                            sh       <= {16'(score), SCORE_W'(0)};
                            hex_wait <= 1'b1;
                            state    <= DONE;
                        end else begin
                            sh      <= {16'h0000, sat};
                            bit_cnt <= '0;
                            state   <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    sh      <= sh_shift;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == BIT_W'(SCORE_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Hex results sit one extra cycle so commit lands two edges after the handshake.
                    if (hex_wait) begin
                        hex_wait <= 1'b0;
                    end else begin
                        state       <= IDLE;
                        score_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Sequencing controller for the 4-digit HEX score readout of the Bricks game.
- Accepts binary score updates over a valid/ready handshake and converts them to BCD with a sequential double-dabble engine, one bit per cycle.
- Holds the committed digits, generates leading-zero and blink blanking, and presents 4-bit digit codes plus a blank mask to the per-digit seven-segment decoders at top level.

Parameters:
SCORE_W, 14, binary score width (max input 16383)
BLINK_DIV, 25000000, blink half-period in clk cycles (must be >=1)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active low
score_valid  input  1  new score offered
score  input  14  binary score value
hex_mode  input  1  1 = display score as raw hex (no BCD conversion); sampled at handshake
score_ready  output  1  controller can accept a score
blink_en  input  1  1 = blink whole display (game over)
digits  output  16  committed digit codes; [3:0] = ones/LS digit, [15:12] = MS digit
blank  output  4  per-digit blank mask; bit i blanks digits[4i+3:4i]
busy  output  1  conversion in progress (state != IDLE)

Behaviour:
- Single clock domain. Reset is synchronous and active-low: all state updates on rising clk, rst_n sampled at the edge.
- Reset values:
  - state IDLE; score_ready 0 while rst_n low, 1 in the first cycle after release.
  - digits 16'h0000; blank 4'b1110 (displays "0"); busy 0.
  - Blink counter 0; blink phase ON.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - score_ready = 1.
  - On score_valid & score_ready at edge E0:
    - If hex_mode = 1: latch {2'b00, score} into the result register, go to DONE.
    - Otherwise: load a 30-bit shift register {16'h0, sat}, where sat = (score > 9999) ? 9999 : score. Clear the bit counter, go to SHIFT.
- SHIFT, one iteration per edge:
  - For each of the 4 BCD nibbles, add 3 if the nibble >= 5.
  - Then shift the whole 30-bit register left by 1. Increment the counter.
  - After the 14th iteration (edge E14), go to DONE.
- DONE, one edge:
  - Commit the BCD nibbles (or the hex value) to digits.
  - Compute the leading-zero mask, go to IDLE.
  - Decimal path: digits valid after E15. Hex path: digits valid after E2.
- score_ready = 0 in SHIFT and DONE. score_valid outside IDLE is ignored; upstream must hold it. score is not re-sampled during conversion.
- Back-to-back updates: next handshake possible at the edge after commit (E16 decimal). Maximum rate is 1 update per 16 cycles.
- Leading-zero mask (lz), registered at commit:
  - lz[3] = (d3 == 0)
  - lz[2] = lz[3] & (d2 == 0)
  - lz[1] = lz[2] & (d1 == 0)
  - lz[0] = 0 (ones digit never blanked)
  - The same rule applies in hex mode.
- Blink:
  - While blink_en = 1, the counter counts 0..BLINK_DIV-1. The phase toggles at the wrap.
  - While blink_en = 0, the counter is held at 0 and the phase is forced ON.
  - The first OFF phase begins BLINK_DIV cycles after blink_en rises.
- blank output (registered) = lz | {4{phase == OFF}}.
- digits stay stable between commits. A new commit during an OFF phase updates digits without altering the blink phase.
- Reset mid-conversion aborts immediately: digits return to 0, and the partial result is discarded.
- No arithmetic overflow: the BCD nibbles never exceed 9 given saturation at 9999.

Test Plan:
- Reset, then score = 1234, hex_mode = 0, single-cycle valid handshake -> score_ready low for 15 cycles; digits = 16'h1234 and blank = 4'b0000 after E15; ready high again.
- score = 7 -> digits = 16'h0007, blank = 4'b1110. Then score = 0 -> digits = 16'h0000, blank = 4'b1110. Then score = 905 -> digits = 16'h0905, blank = 4'b1000.
- score = 12000 and score = 16383 -> digits = 16'h9999, blank = 4'b0000 (saturation).
- hex_mode = 1, score = 14'h0ABC -> digits = 16'h0ABC after E2, blank = 4'b1000, ready low only 2 cycles.
- BLINK_DIV = 4 in the bench, blink_en = 1 with digits 16'h0042:
  - blank alternates 4'b1100 / 4'b1111 every 4 cycles.
  - Drop blink_en -> blank = 4'b1100 on the next cycle.
- Start conversion of 5678, assert rst_n = 0 at E7 for 1 cycle -> digits = 0, blank = 4'b1110, ready = 1 after release. Then hold score_valid continuously with 4321 then 8765 -> both commit in order, 16 cycles apart.
